// File: rtl/instr_mem_prog.sv
// Programmable instruction memory: registered fetch port with stall/flush and
// fault flags, plus a valid/ready load port that writes an image and NOP-fills the tail.
module instr_mem_prog #(
  parameter int                 DATA_W    = 32,
  parameter int                 DEPTH     = 128,
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter logic [DATA_W-1:0]  NOP_WORD  = '0
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic [ADDR_W-1:0]            PC,
  input  logic                         Stall,
  input  logic                         Flush,
  output logic [DATA_W-1:0]            Instr,
  output logic                         InstrValid,
  output logic                         PCFault,
  output logic                         MemReady,
  input  logic                         LoadStart,
  input  logic                         LoadValid,
  input  logic [DATA_W-1:0]            LoadData,
  input  logic                         LoadLast,
  output logic                         LoadReady,
  output logic [$clog2(DEPTH+1)-1:0]   LoadCount
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_INIT_CLEAR,
    ST_RUN,
    ST_LOAD,
    ST_CLEAR
  } state_t;

  state_t              state_reg, state_next;
  logic [PTR_W-1:0]    ptr_reg, ptr_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic                wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic                last_ptr;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign last_ptr = (ptr_reg == PTR_W'(DEPTH - 1));

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_reg <= ST_INIT_CLEAR;
      ptr_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    count_next = count_reg;
    case (state_reg)
      ST_INIT_CLEAR, ST_CLEAR: begin
        if (last_ptr) begin
          state_next = ST_RUN;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr_reg + PTR_W'(1);
        end
      end
      ST_RUN: begin
        // A LoadValid arriving with LoadStart is ignored; data flows from LOAD on.
        if (LoadStart) begin
          state_next = ST_LOAD;
          ptr_next   = '0;
          count_next = '0;
        end
      end
      ST_LOAD: begin
        if (LoadValid) begin
          count_next = count_reg + CNT_W'(1);
          if (last_ptr) begin
            state_next = ST_RUN;
            ptr_next   = '0;
          end else begin
            ptr_next = ptr_reg + PTR_W'(1);
            if (LoadLast) state_next = ST_CLEAR;
          end
        end
      end
      default: state_next = ST_INIT_CLEAR;
    endcase
  end

  always_comb begin
    MemReady  = (state_reg == ST_RUN);
    LoadReady = (state_reg == ST_LOAD);
    LoadCount = count_reg;
    wr_en     = 1'b0;
    wr_data   = NOP_WORD;
    case (state_reg)
      ST_INIT_CLEAR, ST_CLEAR: wr_en = 1'b1;
      ST_LOAD: begin
        wr_en   = LoadValid;
        wr_data = LoadData;
      end
      default: wr_en = 1'b0;
    endcase
  end

  // Single write port; writes never occur in RUN, so fetch never sees a collision.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[ptr_reg] <= wr_data;
  end

  logic [ADDR_W:0]   off_words;
  logic [PTR_W-1:0]  rd_idx;
  logic              in_range;
  logic              aligned;

  assign off_words = ({1'b0, PC} - {1'b0, BASE_ADDR}) >> 2;
  assign in_range  = (PC >= BASE_ADDR) && (off_words < (ADDR_W+1)'(DEPTH));
  assign aligned   = (PC[1:0] == 2'b00);
  assign rd_idx    = off_words[PTR_W-1:0];

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      Instr      <= NOP_WORD;
      InstrValid <= 1'b0;
      PCFault    <= 1'b0;
    end else if ((state_reg != ST_RUN) || Flush) begin
      Instr      <= NOP_WORD;
      InstrValid <= 1'b0;
      PCFault    <= 1'b0;
    end else if (!Stall) begin
      InstrValid <= 1'b1;
      if (in_range && aligned) begin
        Instr   <= mem[rd_idx];
        PCFault <= 1'b0;
      end else begin
        Instr   <= NOP_WORD;
        PCFault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_prog.sv
// Directed bench for instr_mem_prog: init clear, image load with tail fill,
// fetch faults, stall/flush, full-depth load and reset abort.
module tb_instr_mem_prog;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] PC;
  logic        Stall, Flush;
  logic [31:0] Instr;
  logic        InstrValid, PCFault, MemReady;
  logic        LoadStart, LoadValid, LoadLast, LoadReady;
  logic [31:0] LoadData;
  logic [7:0]  LoadCount;

  logic [31:0] pc_b;
  logic [31:0] instr_b;
  logic        valid_b, fault_b, ready_b, load_ready_b;
  logic [4:0]  count_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] fib [15] = '{
    32'hE2000000, 32'hE2801001, 32'hE2802000, 32'hE3A0300A, 32'hE0824001,
    32'hE1A02001, 32'hE1A01004, 32'hE2533001, 32'hE5804000, 32'hE2800004,
    32'hE3530000, 32'hE1A00000, 32'hE1A00000, 32'hE2533000, 32'h1AFFFFF8
  };

  always #5 CLK = ~CLK;

  instr_mem_prog dut (
    .CLK(CLK), .Reset(Reset), .PC(PC), .Stall(Stall), .Flush(Flush),
    .Instr(Instr), .InstrValid(InstrValid), .PCFault(PCFault), .MemReady(MemReady),
    .LoadStart(LoadStart), .LoadValid(LoadValid), .LoadData(LoadData),
    .LoadLast(LoadLast), .LoadReady(LoadReady), .LoadCount(LoadCount)
  );

  instr_mem_prog #(.DEPTH(16), .BASE_ADDR(32'h100)) dut_b (
    .CLK(CLK), .Reset(Reset), .PC(pc_b), .Stall(1'b0), .Flush(1'b0),
    .Instr(instr_b), .InstrValid(valid_b), .PCFault(fault_b), .MemReady(ready_b),
    .LoadStart(1'b0), .LoadValid(1'b0), .LoadData(32'h0),
    .LoadLast(1'b0), .LoadReady(load_ready_b), .LoadCount(count_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int n = 0;
    while (!MemReady && n < 1000) begin
      tick();
      n++;
    end
    check_val(tag, n, exp_cycles);
  endtask

  task automatic fetch(input logic [31:0] pc);
    PC = pc;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; PC = '0; Stall = 1'b0; Flush = 1'b0;
    LoadStart = 1'b0; LoadValid = 1'b0; LoadLast = 1'b0; LoadData = '0;
    pc_b = 32'h100;
    tick(); tick(); tick();
    check_val("rst_instr", Instr, 32'h0);
    check_val("rst_valid", {31'b0, InstrValid}, 32'd0);
    check_val("rst_fault", {31'b0, PCFault}, 32'd0);
    check_val("rst_ready", {31'b0, MemReady}, 32'd0);
    check_val("rst_load_ready", {31'b0, LoadReady}, 32'd0);
    check_val("rst_count", {24'b0, LoadCount}, 32'd0);

    Reset = 1'b0;
    wait_ready("init_cycles", 128);

    fetch(32'h40);
    check_val("init_instr_40", Instr, 32'h0);
    check_val("init_valid_40", {31'b0, InstrValid}, 32'd1);
    check_val("init_fault_40", {31'b0, PCFault}, 32'd0);

    // Offset-base instance: range edges around BASE_ADDR=0x100, DEPTH=16
    pc_b = 32'hFC;  tick();
    check_val("b_fault_fc", {31'b0, fault_b}, 32'd1);
    check_val("b_valid_fc", {31'b0, valid_b}, 32'd1);
    pc_b = 32'h100; tick();
    check_val("b_fault_100", {31'b0, fault_b}, 32'd0);
    pc_b = 32'h13C; tick();
    check_val("b_fault_13c", {31'b0, fault_b}, 32'd0);
    pc_b = 32'h140; tick();
    check_val("b_fault_140", {31'b0, fault_b}, 32'd1);
    pc_b = 32'h102; tick();
    check_val("b_fault_102", {31'b0, fault_b}, 32'd1);

    // Fibonacci image, LoadValid gap after word 5
    LoadStart = 1'b1; tick(); LoadStart = 1'b0;
    check_val("fib_load_ready", {31'b0, LoadReady}, 32'd1);
    check_val("fib_mem_ready", {31'b0, MemReady}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      if (i == 5) begin
        LoadValid = 1'b0;
        tick(); tick();
        check_val("fib_gap_count", {24'b0, LoadCount}, 32'd5);
      end
      LoadValid = 1'b1;
      LoadData  = fib[i];
      LoadLast  = (i == 14);
      tick();
    end
    LoadValid = 1'b0; LoadLast = 1'b0;
    check_val("fib_count", {24'b0, LoadCount}, 32'd15);
    check_val("fib_clear_load_ready", {31'b0, LoadReady}, 32'd0);
    check_val("fib_clear_valid", {31'b0, InstrValid}, 32'd0);
    wait_ready("fib_clear_cycles", 113);

    for (int i = 0; i < 15; i++) begin
      fetch(32'(i * 4));
      check_val($sformatf("fib_word_%0d", i), Instr, fib[i]);
    end
    fetch(32'h3C);
    check_val("fib_tail_3c", Instr, 32'h0);

    // Fault cases
    fetch(32'h200);
    check_val("fault_200", {31'b0, PCFault}, 32'd1);
    check_val("fault_200_instr", Instr, 32'h0);
    check_val("fault_200_valid", {31'b0, InstrValid}, 32'd1);
    fetch(32'h06);
    check_val("fault_06", {31'b0, PCFault}, 32'd1);
    fetch(32'h1FC);
    check_val("edge_1fc_fault", {31'b0, PCFault}, 32'd0);

    // Stall hold, then flush over stall
    fetch(32'h04);
    check_val("stall_pre", Instr, 32'hE2801001);
    Stall = 1'b1;
    fetch(32'h08);
    check_val("stall_hold", Instr, 32'hE2801001);
    check_val("stall_hold_valid", {31'b0, InstrValid}, 32'd1);
    Flush = 1'b1;
    tick();
    check_val("flush_instr", Instr, 32'h0);
    check_val("flush_valid", {31'b0, InstrValid}, 32'd0);
    Flush = 1'b0; Stall = 1'b0;
    fetch(32'h08);
    check_val("post_flush", Instr, fib[2]);

    // Full-depth load, LoadStart with LoadValid in RUN: only start acts
    LoadStart = 1'b1; LoadValid = 1'b1; LoadData = 32'hDEADBEEF; tick();
    LoadStart = 1'b0;
    check_val("full_start_count", {24'b0, LoadCount}, 32'd0);
    check_val("full_load_ready", {31'b0, LoadReady}, 32'd1);
    for (int i = 0; i < 128; i++) begin
      if (i == 40) begin
        LoadValid = 1'b0;
        tick(); tick(); tick();
        check_val("full_gap_count", {24'b0, LoadCount}, 32'd40);
      end
      LoadValid = 1'b1;
      LoadData  = 32'hA5000000 + 32'(i);
      tick();
    end
    LoadValid = 1'b0;
    check_val("full_run_now", {31'b0, MemReady}, 32'd1);
    check_val("full_count", {24'b0, LoadCount}, 32'd128);
    fetch(32'h0);
    check_val("full_word_0", Instr, 32'hA5000000);
    fetch(32'hA0);
    check_val("full_word_40", Instr, 32'hA5000028);
    fetch(32'h1FC);
    check_val("full_word_127", Instr, 32'hA500007F);

    // Reset during load discards the partial image
    LoadStart = 1'b1; tick(); LoadStart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      LoadValid = 1'b1;
      LoadData  = 32'hB0000000 + 32'(i);
      tick();
    end
    LoadValid = 1'b0;
    check_val("abort_count_pre", {24'b0, LoadCount}, 32'd5);
    #2 Reset = 1'b1;
    #1;
    check_val("abort_ready", {31'b0, MemReady}, 32'd0);
    check_val("abort_load_ready", {31'b0, LoadReady}, 32'd0);
    check_val("abort_count", {24'b0, LoadCount}, 32'd0);
    check_val("abort_valid", {31'b0, InstrValid}, 32'd0);
    tick(); tick();
    Reset = 1'b0;
    wait_ready("abort_init_cycles", 128);
    fetch(32'h0);
    check_val("abort_word_0", Instr, 32'h0);
    fetch(32'h10);
    check_val("abort_word_4", Instr, 32'h0);
    fetch(32'h1FC);
    check_val("abort_word_127", Instr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
